// File: rtl/bin2bcd_serial.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Ports: clk, rst_n, start, bin_in, g_n (blank) -> busy, done, ovf, bcd_out.
module bin2bcd_serial #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin_in,
  input  logic                g_n,
  output logic                busy,
  output logic                done,
  output logic                ovf,
  output logic [4*DIGITS-1:0] bcd_out
);

  localparam int AW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [BIN_W-1:0]  sreg_q, sreg_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [AW-1:0]     adj;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovi_q, ovi_d;
  logic [AW-1:0]     res_q, res_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  // Per-digit +3 correction; digits never carry into each other.
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovi_d   = ovi_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sreg_d  = bin_in;
          acc_d   = '0;
          cnt_d   = CW'(BIN_W);
          ovi_d   = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // A set MSB here would be shifted out: value too big.
        ovi_d  = ovi_q | adj[AW-1];
        acc_d  = {adj[AW-2:0], sreg_q[BIN_W-1]};
        sreg_d = {sreg_q[BIN_W-2:0], 1'b0};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        res_d   = ovi_q ? '1 : acc_q;
        ovf_d   = ovi_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovi_q   <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovi_q   <= ovi_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign ovf     = ovf_q;
  assign bcd_out = g_n ? '1 : res_q;

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Scoreboard bench for bin2bcd_serial.
// Three instances: 16b/5d, 6b/2d and 16b/4d.
module tb_bin2bcd_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start_a = 0, g_a = 0, busy_a, done_a, ovf_a;
  logic [15:0] bin_a = '0;
  logic [19:0] bcd_a;
  logic        start_b = 0, g_b = 0, busy_b, done_b, ovf_b;
  logic [5:0]  bin_b = '0;
  logic [7:0]  bcd_b;
  logic        start_c = 0, g_c = 0, busy_c, done_c, ovf_c;
  logic [15:0] bin_c = '0;
  logic [15:0] bcd_c;

  bin2bcd_serial #(.BIN_W(16), .DIGITS(5)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bin_in(bin_a),
    .g_n(g_a), .busy(busy_a), .done(done_a), .ovf(ovf_a),
    .bcd_out(bcd_a));
  bin2bcd_serial #(.BIN_W(6), .DIGITS(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bin_in(bin_b),
    .g_n(g_b), .busy(busy_b), .done(done_b), .ovf(ovf_b),
    .bcd_out(bcd_b));
  bin2bcd_serial #(.BIN_W(16), .DIGITS(4)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .bin_in(bin_c),
    .g_n(g_c), .busy(busy_c), .done(done_c), .ovf(ovf_c),
    .bcd_out(bcd_c));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [63:0] bcd;
    logic [63:0] msk;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  function automatic exp_t model(input int unsigned v, input int dig,
                                 input int c);
    exp_t e;
    longint unsigned lim = 1;
    int unsigned t = v;
    for (int i = 0; i < dig; i++) lim = lim * 10;
    e.msk = (64'd1 << (4 * dig)) - 64'd1;
    e.cyc = c;
    e.bcd = '0;
    e.ovf = (64'(v) >= lim);
    if (e.ovf) begin
      e.bcd = e.msk;
    end else begin
      for (int i = 0; i < dig; i++) begin
        e.bcd[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
    end
    return e;
  endfunction

  function automatic int qsize(input int w);
    case (w)
      0: return qa.size();
      1: return qb.size();
      default: return qc.size();
    endcase
  endfunction

  task automatic sb(input int w, input string nm, input logic [63:0] bcd,
                    input logic ov, input logic bsy, input logic g);
    exp_t e;
    int n;
    n = qsize(w);
    chk({nm, "_expected_done"}, 64'(n > 0), 64'd1);
    if (n > 0) begin
      case (w)
        0: e = qa.pop_front();
        1: e = qb.pop_front();
        default: e = qc.pop_front();
      endcase
      chk({nm, "_latency"}, 64'(cyc), 64'(e.cyc));
      chk({nm, "_bcd"}, bcd, g ? e.msk : e.bcd);
      chk({nm, "_ovf"}, 64'(ov), 64'(e.ovf));
      chk({nm, "_busy_at_done"}, 64'(bsy), 64'd0);
    end
  endtask

  always @(negedge clk) if (done_a) sb(0, "a", 64'(bcd_a), ovf_a, busy_a, g_a);
  always @(negedge clk) if (done_b) sb(1, "b", 64'(bcd_b), ovf_b, busy_b, g_b);
  always @(negedge clk) if (done_c) sb(2, "c", 64'(bcd_c), ovf_c, busy_c, g_c);

  task automatic go(input int w, input int unsigned v);
    @(negedge clk);
    case (w)
      0: begin start_a = 1; bin_a = v[15:0]; end
      1: begin start_b = 1; bin_b = v[5:0]; end
      default: begin start_c = 1; bin_c = v[15:0]; end
    endcase
    @(posedge clk);
    #1;
    case (w)
      0: qa.push_back(model(v, 5, cyc + 17));
      1: qb.push_back(model(v, 2, cyc + 7));
      default: qc.push_back(model(v, 4, cyc + 17));
    endcase
    @(negedge clk);
    start_a = 0;
    start_b = 0;
    start_c = 0;
  endtask

  task automatic drain(input int w);
    int n;
    n = qsize(w);
    for (int i = 0; i < 200 && n != 0; i++) begin
      @(negedge clk);
      n = qsize(w);
    end
    chk("drain", 64'(n), 64'd0);
    @(negedge clk);
  endtask

  int unsigned bb[3] = '{17, 39, 40};

  initial begin
    #12;
    chk("rst_busy", 64'(busy_c), 64'd0);
    chk("rst_done", 64'(done_c), 64'd0);
    chk("rst_ovf", 64'(ovf_c), 64'd0);
    chk("rst_bcd", 64'(bcd_c), 64'd0);
    g_c = 1;
    #1;
    chk("rst_bcd_blank", 64'(bcd_c), 64'hFFFF);
    g_c = 0;
    @(negedge clk);
    rst_n = 1;

    go(0, 65535);
    drain(0);

    for (int v = 0; v <= 40; v++) begin
      go(1, v);
      drain(1);
    end

    @(negedge clk);
    start_b = 1;
    bin_b = bb[0][5:0];
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      qb.push_back(model(bb[k], 2, cyc + 7));
      @(negedge clk);
      if (k < 2) begin
        bin_b = bb[k+1][5:0];
        repeat (7) @(posedge clk);
      end else begin
        start_b = 0;
      end
    end
    drain(1);

    go(2, 10000);
    drain(2);

    go(2, 777);
    repeat (4) @(negedge clk);
    rst_n = 0;
    qc.delete();
    #1;
    chk("abort_busy", 64'(busy_c), 64'd0);
    chk("abort_done", 64'(done_c), 64'd0);
    chk("abort_ovf", 64'(ovf_c), 64'd0);
    chk("abort_bcd", 64'(bcd_c), 64'd0);
    @(negedge clk);
    rst_n = 1;
    repeat (30) @(negedge clk);
    go(2, 1234);
    drain(2);

    go(2, 9999);
    drain(2);

    go(2, 321);
    repeat (2) @(negedge clk);
    start_c = 1;
    bin_c = 16'd555;
    @(negedge clk);
    start_c = 0;
    drain(2);
    repeat (25) @(negedge clk);
    chk("ignored_bcd", 64'(bcd_c), 64'h0321);

    go(2, 42);
    repeat (2) @(negedge clk);
    g_c = 1;
    #1;
    chk("blank_mid_bcd", 64'(bcd_c), 64'hFFFF);
    chk("blank_mid_busy", 64'(busy_c), 64'd1);
    @(negedge clk);
    g_c = 0;
    #1;
    chk("hold_prev_bcd", 64'(bcd_c), 64'h0321);
    drain(2);
    chk("g42_bcd", 64'(bcd_c), 64'h0042);
    g_c = 1;
    #1;
    chk("g42_blank", 64'(bcd_c), 64'hFFFF);
    chk("g42_ovf", 64'(ovf_c), 64'd0);
    g_c = 0;
    #1;
    chk("g42_unblank", 64'(bcd_c), 64'h0042);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
